// File: rtl/axi4_pkg.sv
// Shared types and constants for the single-beat AXI4 register-bank responder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package axi4_pkg;

    localparam int AXI_ADDR_W = 32;
    localparam int AXI_DATA_W = 32;

    // Write side: accepting AW/W beats, or holding a B response.
    typedef enum logic {
        W_IDLE = 1'b0,
        W_RESP = 1'b1
    } w_state_e;

    // Read side: accepting AR, or holding R data.
    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } r_state_e;

    // Value returned for a read that misses the register bank.
    localparam logic [AXI_DATA_W-1:0] OOR_RDATA = 32'h0;

endpackage

// File: rtl/axi4_slave_if.sv
// Five-channel single-beat AXI4 bundle (AW, W, B, AR, R) between master and responder.
// Latency: n/a (wiring only).
// Backpressure: valid/ready per channel.
interface axi4_slave_if;
    import axi4_pkg::*;

    logic [AXI_ADDR_W-1:0] awaddr;
    logic                  awvalid;
    logic                  awready;
    logic [AXI_DATA_W-1:0] wdata;
    logic                  wvalid;
    logic                  wready;
    logic                  bvalid;
    logic                  bready;
    logic [AXI_ADDR_W-1:0] araddr;
    logic                  arvalid;
    logic                  arready;
    logic [AXI_DATA_W-1:0] rdata;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output awaddr, awvalid, wdata, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bvalid, arready, rdata, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bvalid, arready, rdata, rvalid
    );

endinterface

// File: rtl/axi4_slave_mem.sv
// DEPTH x 32 register array: one synchronous write port, one combinational read port.
// Latency: write visible on the cycle after the write edge; read is same-cycle from flops.
// Backpressure: none; every write request is taken, reset clears every word.
module axi4_slave_mem
    import axi4_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         we,
    input  logic [$clog2(DEPTH)-1:0]     waddr,
    input  logic [AXI_DATA_W-1:0]        wdata,
    input  logic [$clog2(DEPTH)-1:0]     raddr,
    output logic [AXI_DATA_W-1:0]        rdata
);

    logic [AXI_DATA_W-1:0] mem_q [DEPTH];
    logic [AXI_DATA_W-1:0] mem_d [DEPTH];

    // Next array contents: copy, then overlay the single write.
    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[waddr] = wdata;
        end
    end

    // Reading the current flops gives read-before-write on a same-edge collision.
    assign rdata = mem_q[raddr];

    // Array storage with synchronous clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

endmodule

// File: rtl/axi4_slave.sv
// AXI4 single-beat responder backed by a DEPTH-word register bank; independent read and write FSMs.
// Latency: B one cycle after the later of AW/W handshakes; R one cycle after AR handshake.
// Backpressure: bvalid/rvalid and rdata hold until accepted; no new AW/W/AR while a response is pending.
module axi4_slave
    import axi4_pkg::*;
#(
    parameter int              DEPTH     = 16,
    parameter logic [31:0]     BASE_ADDR = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          reset,
    axi4_slave_if.slave   s
);

    localparam int IW      = $clog2(DEPTH);
    localparam int TAG_LSB = 2 + IW;

    // Address hits the bank when every bit above the word index matches the base.
    function automatic logic in_range(input logic [AXI_ADDR_W-1:0] a);
        return (a >> TAG_LSB) == (BASE_ADDR >> TAG_LSB);
    endfunction

    w_state_e              w_state_q, w_state_d;
    logic                  aw_held_q, aw_held_d;
    logic                  w_held_q,  w_held_d;
    logic [AXI_ADDR_W-1:0] awaddr_q,  awaddr_d;
    logic [AXI_DATA_W-1:0] wdata_q,   wdata_d;
    logic                  awready_q, awready_d;
    logic                  wready_q,  wready_d;
    logic                  bvalid_q,  bvalid_d;

    r_state_e              r_state_q, r_state_d;
    logic                  arready_q, arready_d;
    logic                  rvalid_q,  rvalid_d;
    logic [AXI_DATA_W-1:0] rdata_q,   rdata_d;

    logic                  aw_hs, w_hs, ar_hs;
    logic [AXI_ADDR_W-1:0] addr_cur;
    logic [AXI_DATA_W-1:0] data_cur;
    logic                  mem_we;
    logic [AXI_DATA_W-1:0] mem_rdata;
    logic                  unused_addr_lsbs;

    assign aw_hs    = s.awvalid & awready_q;
    assign w_hs     = s.wvalid  & wready_q;
    assign ar_hs    = s.arvalid & arready_q;
    // A held beat takes priority; otherwise the beat handshaking right now is used.
    assign addr_cur = aw_held_q ? awaddr_q : s.awaddr;
    assign data_cur = w_held_q  ? wdata_q  : s.wdata;
    assign unused_addr_lsbs = &{1'b0, addr_cur[1:0], s.araddr[1:0]};

    axi4_slave_mem #(.DEPTH(DEPTH)) u_mem (
        .clk   (clk),
        .reset (reset),
        .we    (mem_we),
        .waddr (addr_cur[2 +: IW]),
        .wdata (data_cur),
        .raddr (s.araddr[2 +: IW]),
        .rdata (mem_rdata)
    );

    // Write FSM: collect AW and W in any order, commit once both are present, then hold B.
    always_comb begin
        w_state_d = w_state_q;
        aw_held_d = aw_held_q;
        w_held_d  = w_held_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        awready_d = awready_q;
        wready_d  = wready_q;
        bvalid_d  = bvalid_q;
        mem_we    = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                if (aw_hs) begin
                    aw_held_d = 1'b1;
                    awaddr_d  = s.awaddr;
                end
                if (w_hs) begin
                    w_held_d = 1'b1;
                    wdata_d  = s.wdata;
                end
                if ((aw_held_q | aw_hs) && (w_held_q | w_hs)) begin
                    // Out-of-range writes are dropped but still answered.
                    mem_we    = in_range(addr_cur);
                    aw_held_d = 1'b0;
                    w_held_d  = 1'b0;
                    w_state_d = W_RESP;
                    bvalid_d  = 1'b1;
                    awready_d = 1'b0;
                    wready_d  = 1'b0;
                end else begin
                    awready_d = !aw_held_d;
                    wready_d  = !w_held_d;
                end
            end
            W_RESP: begin
                if (s.bready) begin
                    w_state_d = W_IDLE;
                    bvalid_d  = 1'b0;
                    awready_d = 1'b1;
                    wready_d  = 1'b1;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // Read FSM: capture data on AR handshake, hold R until accepted.
    always_comb begin
        r_state_d = r_state_q;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        case (r_state_q)
            R_IDLE: begin
                if (ar_hs) begin
                    rdata_d   = in_range(s.araddr) ? mem_rdata : OOR_RDATA;
                    rvalid_d  = 1'b1;
                    arready_d = 1'b0;
                    r_state_d = R_DATA;
                end else begin
                    arready_d = 1'b1;
                end
            end
            R_DATA: begin
                if (s.rready) begin
                    rvalid_d  = 1'b0;
                    arready_d = 1'b1;
                    r_state_d = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    // State and registered outputs for both FSMs; reset aborts any transaction.
    always_ff @(posedge clk) begin
        if (reset) begin
            w_state_q <= W_IDLE;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            r_state_q <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
        end else begin
            w_state_q <= w_state_d;
            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            r_state_q <= r_state_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
        end
    end

    assign s.awready = awready_q;
    assign s.wready  = wready_q;
    assign s.bvalid  = bvalid_q;
    assign s.arready = arready_q;
    assign s.rvalid  = rvalid_q;
    assign s.rdata   = rdata_q;

endmodule

// File: tb/tb_axi4_slave.sv
// Self-checking bench for axi4_slave against a word-array reference model.
// Latency: n/a.
// Backpressure: exercised by holding bready/rready low.
module tb_axi4_slave;
    import axi4_pkg::*;

    localparam int          DEPTH = 16;
    localparam logic [31:0] BASE  = 32'h0000_0000;
    localparam logic [31:0] SPAN  = 32'(DEPTH * 4);

    logic clk   = 1'b0;
    logic reset = 1'b1;

    axi4_slave_if bus ();

    axi4_slave #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .clk   (clk),
        .reset (reset),
        .s     (bus)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] model [DEPTH];

    function automatic bit model_hit(input logic [31:0] a);
        return (a / SPAN) == (BASE / SPAN);
    endfunction

    function automatic int model_idx(input logic [31:0] a);
        return int'((a % SPAN) / 4);
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        return model_hit(a) ? model[model_idx(a)] : 32'h0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
    endtask

    // mode 0: AW and W together; 1: AW first; 2: W first. gap = idle cycles between them.
    task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                            input int mode, input int gap, input int bp);
        n_checks++;
        if ({bus.awready, bus.wready, bus.bvalid} !== 3'b110) begin
            n_fail++;
            $display("FAIL wr_idle_ready: got %b expected 110", {bus.awready, bus.wready, bus.bvalid});
        end
        if (mode == 0) begin
            bus.awaddr = a; bus.awvalid = 1'b1; bus.wdata = d; bus.wvalid = 1'b1;
            tick();
            bus.awvalid = 1'b0; bus.wvalid = 1'b0;
            bus.awaddr = $urandom; bus.wdata = $urandom;
        end else begin
            if (mode == 1) begin bus.awaddr = a; bus.awvalid = 1'b1; end
            else           begin bus.wdata  = d; bus.wvalid  = 1'b1; end
            tick();
            bus.awvalid = 1'b0; bus.wvalid = 1'b0;
            bus.awaddr = $urandom; bus.wdata = $urandom;
            for (int g = 0; g <= gap; g++) begin
                n_checks++;
                if ({bus.awready, bus.wready, bus.bvalid} !== ((mode == 1) ? 3'b010 : 3'b100)) begin
                    n_fail++;
                    $display("FAIL wr_first_held: got %b expected %b", {bus.awready, bus.wready, bus.bvalid},
                             (mode == 1) ? 3'b010 : 3'b100);
                end
                if (g < gap) tick();
            end
            if (mode == 1) begin bus.wdata  = d; bus.wvalid  = 1'b1; end
            else           begin bus.awaddr = a; bus.awvalid = 1'b1; end
            tick();
            bus.awvalid = 1'b0; bus.wvalid = 1'b0;
            bus.awaddr = $urandom; bus.wdata = $urandom;
        end
        n_checks++;
        if ({bus.bvalid, bus.awready, bus.wready} !== 3'b100) begin
            n_fail++;
            $display("FAIL bvalid_latency: got %b expected 100", {bus.bvalid, bus.awready, bus.wready});
        end
        if (model_hit(a)) model[model_idx(a)] = d;
        for (int i = 0; i < bp; i++) begin
            tick();
            n_checks++;
            if ({bus.bvalid, bus.awready, bus.wready} !== 3'b100) begin
                n_fail++;
                $display("FAIL b_backpressure: cycle %0d got %b expected 100", i, {bus.bvalid, bus.awready, bus.wready});
            end
        end
        bus.bready = 1'b1;
        tick();
        bus.bready = 1'b0;
        n_checks++;
        if ({bus.bvalid, bus.awready, bus.wready} !== 3'b011) begin
            n_fail++;
            $display("FAIL b_release: got %b expected 011", {bus.bvalid, bus.awready, bus.wready});
        end
    endtask

    task automatic do_read(input logic [31:0] a, input int bp);
        logic [31:0] exp_d;
        exp_d = model_read(a);
        n_checks++;
        if ({bus.arready, bus.rvalid} !== 2'b10) begin
            n_fail++;
            $display("FAIL rd_idle_ready: got %b expected 10", {bus.arready, bus.rvalid});
        end
        bus.araddr = a; bus.arvalid = 1'b1;
        tick();
        bus.arvalid = 1'b0; bus.araddr = $urandom;
        n_checks++;
        if ({bus.rvalid, bus.arready} !== 2'b10 || bus.rdata !== exp_d) begin
            n_fail++;
            $display("FAIL rdata addr %h: got v=%b d=%h expected v=1 d=%h", a, bus.rvalid, bus.rdata, exp_d);
        end
        for (int i = 0; i < bp; i++) begin
            tick();
            n_checks++;
            if ({bus.rvalid, bus.arready} !== 2'b10 || bus.rdata !== exp_d) begin
                n_fail++;
                $display("FAIL r_backpressure: cycle %0d got v=%b d=%h expected v=1 d=%h", i, bus.rvalid, bus.rdata, exp_d);
            end
        end
        bus.rready = 1'b1;
        tick();
        bus.rready = 1'b0;
        n_checks++;
        if ({bus.rvalid, bus.arready} !== 2'b01) begin
            n_fail++;
            $display("FAIL r_release: got %b expected 01", {bus.rvalid, bus.arready});
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.arvalid = 1'b1;
        bus.bready = 1'b0; bus.rready = 1'b0;
        bus.awaddr = $urandom; bus.wdata = $urandom; bus.araddr = $urandom;
        tick();
        tick();
        n_checks++;
        if ({bus.awready, bus.wready, bus.bvalid, bus.arready, bus.rvalid} !== 5'b0 || bus.rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b rdata %h expected 00000 rdata 0",
                     {bus.awready, bus.wready, bus.bvalid, bus.arready, bus.rvalid}, bus.rdata);
        end
        bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
        reset = 1'b0;
        tick();
        n_checks++;
        if ({bus.awready, bus.wready, bus.bvalid, bus.arready, bus.rvalid} !== 5'b11010) begin
            n_fail++;
            $display("FAIL reset_release: got %b expected 11010",
                     {bus.awready, bus.wready, bus.bvalid, bus.arready, bus.rvalid});
        end
        clear_model();
    endtask

    task automatic test_basic();
        do_write(32'h0, 32'h1234_5678, 0, 0, 0);
        do_read(32'h0, 0);
    endtask

    task automatic test_out_of_range();
        do_read(32'h4321_1234, 0);
        do_read(32'h4, 0);
    endtask

    task automatic test_w_before_aw();
        do_write(32'h8, 32'hA5A5_A5A5, 2, 1, 0);
        do_read(32'h8, 0);
    endtask

    task automatic test_backpressure();
        do_write(32'hC, $urandom, 1, 0, 5);
        do_read(32'hC, 5);
    endtask

    task automatic test_collision();
        logic [31:0] old_d;
        old_d = model_read(32'h4);
        bus.awaddr = 32'h4; bus.awvalid = 1'b1; bus.wdata = 32'hCAFE_0001; bus.wvalid = 1'b1;
        bus.araddr = 32'h4; bus.arvalid = 1'b1;
        tick();
        bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
        n_checks++;
        if ({bus.bvalid, bus.rvalid} !== 2'b11 || bus.rdata !== old_d) begin
            n_fail++;
            $display("FAIL collision_rbw: got b=%b r=%b d=%h expected b=1 r=1 d=%h",
                     bus.bvalid, bus.rvalid, bus.rdata, old_d);
        end
        model[1] = 32'hCAFE_0001;
        bus.bready = 1'b1; bus.rready = 1'b1;
        tick();
        bus.bready = 1'b0; bus.rready = 1'b0;
        n_checks++;
        if ({bus.awready, bus.wready, bus.bvalid, bus.arready, bus.rvalid} !== 5'b11010) begin
            n_fail++;
            $display("FAIL collision_release: got %b expected 11010",
                     {bus.awready, bus.wready, bus.bvalid, bus.arready, bus.rvalid});
        end
        do_read(32'h4, 0);
    endtask

    task automatic test_random();
        logic [31:0] a;
        for (int it = 0; it < 40; it++) begin
            a = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 63));
            if ($urandom_range(0, 1) == 1) begin
                do_write(a, $urandom, $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2));
            end else begin
                do_read(a, $urandom_range(0, 2));
            end
        end
    endtask

    task automatic test_reset_mid();
        do_write(32'h10, 32'h5EED_0010, 0, 0, 0);
        bus.awaddr = 32'h14; bus.awvalid = 1'b1; bus.wdata = $urandom; bus.wvalid = 1'b1;
        bus.araddr = 32'h10; bus.arvalid = 1'b1;
        tick();
        bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
        n_checks++;
        if ({bus.bvalid, bus.rvalid} !== 2'b11) begin
            n_fail++;
            $display("FAIL mid_pending: got %b expected 11", {bus.bvalid, bus.rvalid});
        end
        reset = 1'b1; bus.bready = 1'b1; bus.rready = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++;
        if ({bus.awready, bus.wready, bus.bvalid, bus.arready, bus.rvalid} !== 5'b0 || bus.rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL mid_reset_outputs: got %b rdata %h expected 00000 rdata 0",
                     {bus.awready, bus.wready, bus.bvalid, bus.arready, bus.rvalid}, bus.rdata);
        end
        tick();
        n_checks++;
        if ({bus.awready, bus.wready, bus.bvalid, bus.arready, bus.rvalid} !== 5'b11010) begin
            n_fail++;
            $display("FAIL mid_no_response: got %b expected 11010",
                     {bus.awready, bus.wready, bus.bvalid, bus.arready, bus.rvalid});
        end
        bus.bready = 1'b0; bus.rready = 1'b0;
        clear_model();
        do_read(32'h10, 0);
    endtask

    initial begin
        bus.awaddr = '0; bus.awvalid = 1'b0; bus.wdata = '0; bus.wvalid = 1'b0;
        bus.bready = 1'b0; bus.araddr = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
        clear_model();
        test_reset();
        test_basic();
        test_out_of_range();
        test_w_before_aw();
        test_backpressure();
        test_collision();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/axi4_slave.md
# axi4_slave

AXI4 responder (memory-mapped register bank) for the five-channel subset driven by the project's AXI4 master: AW, W, B, AR and R, single-beat, 32-bit, with no burst, ID, strobe or response-code signals. The block accepts writes into a DEPTH-word register array and serves reads from it. It sits on the far end of the master's bus and is the default target for system and loopback tests.

## Interface
- DEPTH, 16: number of 32-bit words; power of two, ≥2.
- BASE_ADDR, 32'h0000_0000: byte base address; aligned to DEPTH*4.

- clk  in  1  single clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- awaddr  in  32  write byte address.
- awvalid  in  1  write address valid.
- awready  out  1  write address accepted.
- wdata  in  32  write data.
- wvalid  in  1  write data valid.
- wready  out  1  write data accepted.
- bvalid  out  1  write response valid.
- bready  in  1  master ready for response.
- araddr  in  32  read byte address.
- arvalid  in  1  read address valid.
- arready  out  1  read address accepted.
- rdata  out  32  read data.
- rvalid  out  1  read data valid.
- rready  in  1  master ready for read data.

## Operation
- Handshake on any channel = valid & ready sampled high at a rising edge.
- Decode: index = addr[2 +: log2(DEPTH)]; addr[1:0] ignored. An address is in range iff addr[31:2+log2(DEPTH)] equals the same bits of BASE_ADDR.
- Write FSM states:
  - W_IDLE: awready = !aw_held; wready = !w_held.
  - W_RESP: awready = wready = 0; bvalid = 1.
- AW and W are accepted independently, in either order or on the same edge. A handshaked address or data beat is latched and its held flag is set; the matching ready drops on the next cycle.
- At the edge where both AW and W are available (held or handshaking now):
  - In range: mem[index] <= data. Out of range: write silently dropped.
  - Held flags clear; go to W_RESP.
- W_RESP → W_IDLE on the bvalid & bready edge. Both readies return to 1 on the following cycle.
- Read FSM states:
  - R_IDLE: arready = 1, rvalid = 0.
  - R_DATA: arready = 0, rvalid = 1.
- AR handshake: rdata <= in range ? mem[index] : 32'h0; go to R_DATA. R_DATA → R_IDLE on the rvalid & rready edge.
- Read and write FSMs run concurrently and never stall each other.
- Same-edge write commit and AR handshake to the same index: rdata gets the pre-write value (read-before-write).

## Timing
- All outputs are registered; no combinational input→output path.
- Reset (sampled high): all outputs 0, rdata = 0, both FSMs idle, held flags clear, every mem word = 0.
  - awready, wready and arready rise on the first edge with reset low.
  - Reset mid-transaction aborts it; no response is issued afterwards.
- Write latency: second of AW/W handshakes at edge N → bvalid high from cycle N+1. mem is updated at edge N.
- Read latency: AR handshake at edge N → rvalid high with valid rdata from cycle N+1.
- Throughput: minimum 2 cycles per transaction on each direction.
- Backpressure: bvalid and rvalid stay high, and rdata stays stable, until their handshake. No new AW/W/AR is accepted while the corresponding response is pending.
- Inputs are not required to be stable before their handshake; only handshake-edge values are used.

## Structure
- Package axi4_pkg holds:
  - AXI_ADDR_W = 32 and AXI_DATA_W = 32.
  - The write state enum (W_IDLE, W_RESP) and the read state enum (R_IDLE, R_DATA).
  - The out-of-range read value constant (32'h0).
- Sub-module axi4_slave_mem: DEPTH×32 register array with one synchronous write port, one read port and synchronous clear on reset. The top contains the two FSMs, the held-address/data latches and the decode.

## Test plan
- Write 32'h1234_5678 to 0x0, then read 0x0:
  - bvalid one cycle after the AW/W handshake.
  - rvalid one cycle after the AR handshake, with rdata = 32'h1234_5678.
- Read 0x4321_1234 (out of range, DEPTH=16):
  - rdata = 32'h0000_0000, rvalid after 1 cycle.
  - Memory unchanged; a later read of 0x4 returns its prior value.
- W before AW: wdata 32'hA5A5_A5A5 two cycles before awaddr 0x8:
  - wready low after the W handshake.
  - bvalid the cycle after the AW handshake.
  - A read of 0x8 returns 32'hA5A5_A5A5.
- Backpressure:
  - Hold bready low 5 cycles: bvalid stays 1, awready/wready stay 0.
  - Hold rready low 5 cycles: rdata constant.
  - Each releases one cycle after its handshake.
- Collision: write 32'hCAFE_0001 to 0x4 committing on the same edge as an AR to 0x4 (old value 32'h0):
  - That read returns 32'h0.
  - The next read returns 32'hCAFE_0001.
- Reset while bvalid = 1 and rvalid = 1:
  - Next cycle all outputs are 0 and no B/R handshake completes.
  - A read of a previously written address returns 32'h0.
